// File: rtl/gyro_spi_seq.sv
// gyro_spi_seq: command sequencer in front of a 16-bit SPI master. After power-up it writes
// the sensor configuration registers. On each data-ready interrupt it reads the yaw-rate
// low and high bytes and presents one signed 16-bit sample with a 1-cycle valid strobe.
// Optional feature macro: GYRO_OFFSET_CAL_EN averages the first 2**CAL_SHIFT samples into an
// offset that is then subtracted, with saturation, from every later sample.
module gyro_spi_seq #(
  parameter int unsigned PU_CNT_W  = 16,
  parameter int unsigned CAL_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        init_done,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        cal_done
);

  typedef enum logic [3:0] {
    StPwrWait,
    StInitWr,
    StInitWait,
    StIdle,
    StRdLo,
    StRdLoWait,
    StRdHi,
    StRdHiWait,
    StSample
  } state_e;

  state_e              state_q;
  logic [PU_CNT_W-1:0] pu_cnt_q;
  logic [1:0]          init_idx_q;
  logic [7:0]          lo_q;
  logic                pend_q;
  logic                int_meta_q, int_sync_q, int_prev_q;
  logic                done_q;
  logic                int_edge, done_rise;
  logic [15:0]         init_cmd;
  logic [15:0]         raw;
  logic                sample_take;
  logic [15:0]         sample_yaw;
  logic                sample_vld;
  logic                unused_rd_hi;

  // Only the low byte of each SPI response carries register data.
  assign unused_rd_hi = ^rd_data[15:8];

  assign int_edge    = int_sync_q & ~int_prev_q;
  assign done_rise   = done & ~done_q;
  assign raw         = {rd_data[7:0], lo_q};
  assign sample_take = (state_q == StRdHiWait) && done_rise;

  // Synchronise INT into clk and keep last-cycle copies for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_meta_q <= 1'b0;
      int_sync_q <= 1'b0;
      int_prev_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      int_meta_q <= INT;
      int_sync_q <= int_meta_q;
      int_prev_q <= int_sync_q;
      done_q     <= done;
    end
  end

  // Configuration write table
  always_comb begin
    init_cmd = 16'h0000;
    unique case (init_idx_q)
      2'd0: init_cmd = 16'h0D02;
      2'd1: init_cmd = 16'h1053;
      2'd2: init_cmd = 16'h1150;
      2'd3: init_cmd = 16'h1460;
      default: init_cmd = 16'h0000;
    endcase
  end

`ifdef GYRO_OFFSET_CAL_EN
  localparam int unsigned AccW = 16 + CAL_SHIFT;

  logic [AccW-1:0]      acc_q;
  logic [AccW-1:0]      acc_sum;
  logic [CAL_SHIFT-1:0] cal_cnt_q;
  logic [15:0]          offset_q;
  logic                 cal_done_q;
  logic [16:0]          diff;

  assign acc_sum  = acc_q + {{CAL_SHIFT{raw[15]}}, raw};
  assign diff     = {raw[15], raw} - {offset_q[15], offset_q};
  assign cal_done = cal_done_q;

  // Accumulate the first 2**CAL_SHIFT samples, then freeze their mean as the offset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      cal_cnt_q  <= '0;
      offset_q   <= '0;
      cal_done_q <= 1'b0;
    end else if (sample_take && !cal_done_q) begin
      acc_q     <= acc_sum;
      cal_cnt_q <= cal_cnt_q + CAL_SHIFT'(1);
      if (cal_cnt_q == '1) begin
        // Arithmetic shift of the sum; the mean always fits in 16 bits.
        offset_q   <= acc_sum[AccW-1:CAL_SHIFT];
        cal_done_q <= 1'b1;
      end
    end
  end

  // Offset-corrected sample, clamped when the 17-bit difference leaves 16-bit range
  always_comb begin
    sample_vld = cal_done_q;
    sample_yaw = diff[15:0];
    if (diff[16] != diff[15]) begin
      sample_yaw = diff[16] ? 16'h8000 : 16'h7FFF;
    end
  end
`else
  assign sample_yaw = raw;
  assign sample_vld = 1'b1;
  assign cal_done   = 1'b1;
`endif

  // Sequencer: power-up wait, config writes, then interrupt-driven yaw reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StPwrWait;
      pu_cnt_q   <= '0;
      init_idx_q <= 2'd0;
      lo_q       <= 8'h00;
      pend_q     <= 1'b0;
      wrt        <= 1'b0;
      cmd        <= 16'h0000;
      init_done  <= 1'b0;
      yaw_rt     <= 16'h0000;
      vld        <= 1'b0;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      // Interrupts arriving while busy collapse into one pending read.
      if (int_edge && init_done && (state_q != StIdle)) begin
        pend_q <= 1'b1;
      end
      unique case (state_q)
        StPwrWait: begin
          pu_cnt_q <= pu_cnt_q + PU_CNT_W'(1);
          if (pu_cnt_q == '1) begin
            state_q <= StInitWr;
          end
        end
        StInitWr: begin
          wrt     <= 1'b1;
          cmd     <= init_cmd;
          state_q <= StInitWait;
        end
        StInitWait: begin
          if (done_rise) begin
            if (init_idx_q == 2'd3) begin
              init_done <= 1'b1;
              state_q   <= StIdle;
            end else begin
              init_idx_q <= init_idx_q + 2'd1;
              state_q    <= StInitWr;
            end
          end
        end
        StIdle: begin
          if (int_edge || pend_q) begin
            pend_q  <= 1'b0;
            state_q <= StRdLo;
          end
        end
        StRdLo: begin
          wrt     <= 1'b1;
          cmd     <= 16'hA600;
          state_q <= StRdLoWait;
        end
        StRdLoWait: begin
          if (done_rise) begin
            lo_q    <= rd_data[7:0];
            state_q <= StRdHi;
          end
        end
        StRdHi: begin
          wrt     <= 1'b1;
          cmd     <= 16'hA700;
          state_q <= StRdHiWait;
        end
        StRdHiWait: begin
          if (done_rise) begin
            if (sample_vld) begin
              yaw_rt <= sample_yaw;
              vld    <= 1'b1;
            end
            state_q <= StSample;
          end
        end
        StSample: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StPwrWait;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gyro_spi_seq.sv
// tb_gyro_spi_seq: scoreboard bench for gyro_spi_seq with a small SPI-master responder.
// Build with GYRO_OFFSET_CAL_EN defined to also cover the offset calibration path.
module tb_gyro_spi_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        int_in = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] cmd;
  logic        init_done;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        cal_done;

`ifdef GYRO_OFFSET_CAL_EN
  localparam logic CalEn = 1'b1;
`else
  localparam logic CalEn = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_cmd_q[$];
  logic [15:0] exp_yaw_q[$];

  // Responder knobs and state
  int          lat = 3;
  bit          stale_hold = 1'b0;
  logic [7:0]  lo_b = 8'h00;
  logic [7:0]  hi_b = 8'h00;
  bit          busy = 1'b0;
  int          cnt = 0;
  int          stale_left = 0;
  logic [15:0] cur_cmd = 16'h0000;
  int          wrt_seen = 0;
  int          vld_seen = 0;

  gyro_spi_seq #(
    .PU_CNT_W (4),
    .CAL_SHIFT(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .INT      (int_in),
    .done     (done),
    .rd_data  (rd_data),
    .wrt      (wrt),
    .cmd      (cmd),
    .init_done(init_done),
    .yaw_rt   (yaw_rt),
    .vld      (vld),
    .cal_done (cal_done)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Expected output for a raw sample; calibration offset is 8*0x0010/8 = 0x0010
  function automatic logic [15:0] cooked(logic [15:0] raw);
    logic signed [16:0] d;
    d = $signed({raw[15], raw}) - 17'sd16;
    if (!CalEn) return raw;
    if (d > 17'sd32767) return 16'h7FFF;
    if (d < -17'sd32768) return 16'h8000;
    return d[15:0];
  endfunction

  // Monitor and SPI responder: pops scoreboard on wrt/vld, answers each transaction
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        busy       = 1'b0;
        done       = 1'b0;
        stale_left = 0;
      end else begin
        if (wrt) begin
          wrt_seen++;
          check("wrt_after_done", 16'(busy), 16'd0);
          if (exp_cmd_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL cmd_unexpected: got %h expected none", cmd);
          end else begin
            check("cmd", cmd, exp_cmd_q.pop_front());
          end
          cur_cmd = cmd;
          busy    = 1'b1;
          cnt     = lat;
          if (stale_hold) begin
            stale_left = 3;
          end else begin
            stale_left = 0;
            done       = 1'b0;
          end
        end else if (busy) begin
          if (stale_left > 0) begin
            stale_left--;
            if (stale_left == 0) done = 1'b0;
          end else if (cnt > 1) begin
            cnt--;
          end else begin
            if (cur_cmd == 16'hA600) rd_data = {8'h5A, lo_b};
            else if (cur_cmd == 16'hA700) rd_data = {8'hA5, hi_b};
            else rd_data = 16'h0000;
            done = 1'b1;
            busy = 1'b0;
          end
        end
        if (vld) begin
          vld_seen++;
          if (exp_yaw_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL vld_unexpected: got yaw_rt %h expected no vld", yaw_rt);
          end else begin
            check("yaw_rt", yaw_rt, exp_yaw_q.pop_front());
          end
        end
      end
    end
  end

  task automatic pulse_int();
    @(negedge clk);
    int_in = 1'b1;
    repeat (2) @(negedge clk);
    int_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(string name, int budget);
    int t = 0;
    while ((exp_cmd_q.size() != 0 || exp_yaw_q.size() != 0 || busy) && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= budget) begin
      n_err++;
      $display("FAIL %s: got %0d cmds %0d samples outstanding expected 0 after %0d cycles",
               name, exp_cmd_q.size(), exp_yaw_q.size(), budget);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_cmd(string name, logic [15:0] c, int budget);
    int t = 0;
    while (!(wrt === 1'b1 && cmd === c) && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= budget) begin
      n_err++;
      $display("FAIL %s: got no wrt expected wrt with cmd %h within %0d cycles", name, c, budget);
    end
  endtask

  task automatic wait_init(string name);
    int t = 0;
    while (!init_done && t < 400) begin
      @(negedge clk);
      t++;
    end
    check(name, 16'(init_done), 16'd1);
  endtask

  task automatic push_init();
    exp_cmd_q.push_back(16'h0D02);
    exp_cmd_q.push_back(16'h1053);
    exp_cmd_q.push_back(16'h1150);
    exp_cmd_q.push_back(16'h1460);
  endtask

  task automatic do_read(logic [7:0] lo, logic [7:0] hi, bit expect_vld);
    lo_b = lo;
    hi_b = hi;
    exp_cmd_q.push_back(16'hA600);
    exp_cmd_q.push_back(16'hA700);
    if (expect_vld) exp_yaw_q.push_back(cooked({hi, lo}));
    pulse_int();
    wait_drain("read_pair", 200);
  endtask

  initial begin : stim
    int w0, v0;
    // T1: reset values and configuration sequence
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wrt", 16'(wrt), 16'd0);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_init_done", 16'(init_done), 16'd0);
    check("rst_yaw_rt", yaw_rt, 16'h0000);
    check("rst_vld", 16'(vld), 16'd0);
    check("rst_cal_done", 16'(cal_done), CalEn ? 16'd0 : 16'd1);
    // An interrupt before configuration completes must be dropped.
    push_init();
    rst = 1'b0;
    pulse_int();
    wait_init("init_done_set");
    wait_drain("init_seq", 100);
    check("init_wrt_count", 16'(wrt_seen), 16'd4);
    check("init_no_vld", 16'(vld_seen), 16'd0);

`ifdef GYRO_OFFSET_CAL_EN
    // T6: calibration samples produce no vld, then offset-corrected, saturated output
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("cal_done_before_8th", 16'(cal_done), 16'd0);
      do_read(8'h10, 8'h00, 1'b0);
    end
    check("cal_done_set", 16'(cal_done), 16'd1);
    check("cal_no_vld", 16'(vld_seen), 16'd0);
    do_read(8'h05, 8'h80, 1'b1);
    check("cal_sat_yaw", yaw_rt, 16'h8000);
`endif

    // T2: one interrupt, one read pair, one sample
    v0 = vld_seen;
    do_read(8'h34, 8'h12, 1'b1);
    check("t2_vld_count", 16'(vld_seen - v0), 16'd1);
    do_read(8'hFF, 8'h80, 1'b1);

    // T3: done left high from the previous transaction must not end the next wait
    w0 = wrt_seen;
    stale_hold = 1'b1;
    do_read(8'hCD, 8'hAB, 1'b1);
    stale_hold = 1'b0;
    check("t3_wrt_count", 16'(wrt_seen - w0), 16'd2);

    // T4: three interrupts during the high-byte wait collapse to one extra read pair
    w0 = wrt_seen;
    v0 = vld_seen;
    lat = 25;
    lo_b = 8'h78;
    hi_b = 8'h56;
    repeat (2) begin
      exp_cmd_q.push_back(16'hA600);
      exp_cmd_q.push_back(16'hA700);
      exp_yaw_q.push_back(cooked(16'h5678));
    end
    pulse_int();
    wait_cmd("t4_rd_hi", 16'hA700, 100);
    repeat (3) pulse_int();
    lat = 3;
    wait_drain("t4_drain", 300);
    check("t4_wrt_count", 16'(wrt_seen - w0), 16'd4);
    check("t4_vld_count", 16'(vld_seen - v0), 16'd2);

    // T5: reset in the low-byte wait clears outputs immediately and restarts init
    lat = 10;
    exp_cmd_q.push_back(16'hA600);
    pulse_int();
    wait_cmd("t5_rd_lo", 16'hA600, 50);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_wrt", 16'(wrt), 16'd0);
    check("t5_rst_init_done", 16'(init_done), 16'd0);
    check("t5_rst_vld", 16'(vld), 16'd0);
    check("t5_rst_cmd", cmd, 16'h0000);
    exp_cmd_q.delete();
    exp_yaw_q.delete();
    lat = 3;
    repeat (2) @(negedge clk);
    w0 = wrt_seen;
    push_init();
    rst = 1'b0;
    wait_init("t5_init_done_again");
    wait_drain("t5_init_seq", 100);
    check("t5_init_wrt_count", 16'(wrt_seen - w0), 16'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion expected summary within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
